// File: rtl/msm_bus_arbiter.sv
// Round-robin arbiter multiplexing NREQ requesters onto the single bus_translation
// request port, with a per-transaction completion timeout.
module msm_bus_arbiter #(
  parameter int NREQ      = 4,
  parameter int ADDR_W    = 32,
  parameter int PAYLOAD_W = 128,
  parameter int TIMEOUT   = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_go,
  input  logic [NREQ*ADDR_W-1:0]     req_addr,
  input  logic [NREQ*PAYLOAD_W-1:0]  req_wdata,
  input  logic [NREQ-1:0]            req_rw,
  output logic [NREQ-1:0]            req_done,
  output logic                       req_err,
  output logic [PAYLOAD_W-1:0]       req_rdata,
  output logic [$clog2(NREQ)-1:0]    grant,
  output logic                       busy,
  output logic                       bus_go,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic [PAYLOAD_W-1:0]       bus_write,
  output logic                       bus_RW,
  input  logic                       bus_done,
  input  logic [PAYLOAD_W-1:0]       bus_rdData
);

  localparam int GW = $clog2(NREQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]           state;
  logic [GW-1:0]        last;
  logic [15:0]          count;
  logic [15:0]          count_next;
  logic [GW-1:0]        pick;
  logic [ADDR_W-1:0]    pick_addr;
  logic [PAYLOAD_W-1:0] pick_wdata;
  logic                 pick_rw;
  logic                 found;
  int unsigned          idx;
  logic [NREQ-1:0]      done_vec;

  // Search last+1, last+2, ... so the previous winner ends up lowest priority.
  always_comb begin
    found      = 1'b0;
    idx        = 0;
    pick       = '0;
    pick_addr  = '0;
    pick_wdata = '0;
    pick_rw    = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last) + k) % NREQ;
      if (!found && req_go[GW'(idx)]) begin
        found      = 1'b1;
        pick       = GW'(idx);
        pick_addr  = req_addr[idx*ADDR_W +: ADDR_W];
        pick_wdata = req_wdata[idx*PAYLOAD_W +: PAYLOAD_W];
        pick_rw    = req_rw[GW'(idx)];
      end
    end
  end

  assign count_next = count + 16'd1;
  assign done_vec   = NREQ'(1) << grant;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= GW'(NREQ - 1);
      count     <= '0;
      grant     <= '0;
      bus_go    <= 1'b0;
      bus_addr  <= '0;
      bus_write <= '0;
      bus_RW    <= 1'b0;
      req_done  <= '0;
      req_err   <= 1'b0;
      req_rdata <= '0;
    end else begin
      bus_go   <= 1'b0;
      req_done <= '0;
      case (state)
        IDLE: begin
          if (|req_go) begin
            grant     <= pick;
            bus_addr  <= pick_addr;
            bus_write <= pick_wdata;
            bus_RW    <= pick_rw;
            bus_go    <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          count <= '0;
          state <= WAIT;
        end
        WAIT: begin
          count <= count_next;
          // bus_done takes precedence over a timeout in the same cycle.
          if (bus_done) begin
            req_rdata <= bus_RW ? '0 : bus_rdData;
            req_err   <= 1'b0;
            req_done  <= done_vec;
            last      <= grant;
            state     <= IDLE;
          end else if (count_next == 16'(TIMEOUT)) begin
            req_rdata <= '0;
            req_err   <= 1'b1;
            req_done  <= done_vec;
            last      <= grant;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
